// File: rtl/stepper_driver.sv
// stepper_driver: full-step bipolar stepper driver with rising-edge command intake,
// fixed step period and a signed soft position limit around home.
module stepper_driver #(
    parameter logic [15:0] STEP_PERIOD = 16'd50000,
    parameter logic [15:0] POS_LIMIT   = 16'd200,
    parameter bit          HOLD        = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dir,
    input  logic [7:0]  val,
    input  logic        cmd_valid,
    output logic [3:0]  coil,
    output logic        busy,
    output logic        move_done,
    output logic        limit_hit,
    output logic        cmd_dropped,
    output logic [15:0] position
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam logic signed [15:0] POS_MAX = signed'(POS_LIMIT);
    localparam logic signed [15:0] POS_MIN = -POS_MAX;
    state_t state, state_nx;
    logic cmd_valid_q, rise, dir_q, limit_q, armed, blocked;
    logic [7:0] remaining;
    logic [15:0] timer;
    logic [1:0] index;
    logic signed [15:0] pos;
    always_comb begin
        rise = cmd_valid & ~cmd_valid_q;
        blocked = dir_q ? (pos == POS_MAX) : (pos == POS_MIN);
        state_nx = state == IDLE ? (rise ? (val == 8'd0 ? DONE : WAIT) : IDLE) :
                   state == WAIT ? ((timer == 16'd0 && (blocked || remaining == 8'd1)) ? DONE : WAIT) :
                   IDLE;
        busy = state != IDLE;
        move_done = state == DONE;
        limit_hit = move_done & limit_q;
        position = pos;
        // Coils stay dark after reset until the first move, so reset truly de-energises.
        coil = !(busy || (HOLD && armed)) ? 4'b0000 :
               index == 2'd0 ? 4'b0011 :
               index == 2'd1 ? 4'b0110 :
               index == 2'd2 ? 4'b1100 : 4'b1001;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cmd_valid_q <= 1'b0;
            cmd_dropped <= 1'b0;
            dir_q <= 1'b0;
            limit_q <= 1'b0;
            armed <= 1'b0;
            remaining <= 8'd0;
            timer <= 16'd0;
            index <= 2'd0;
            pos <= 16'sd0;
        end else begin
            state <= state_nx;
            cmd_valid_q <= cmd_valid;
            cmd_dropped <= rise && state != IDLE;
            if (state == IDLE && rise) begin
                dir_q <= dir;
                remaining <= val;
                timer <= STEP_PERIOD - 16'd1;
                limit_q <= 1'b0;
                armed <= 1'b1;
            end else if (state == WAIT) begin
                if (timer != 16'd0)
                    timer <= timer - 16'd1;
                else if (blocked)
                    limit_q <= 1'b1;
                else begin
                    index <= dir_q ? index + 2'd1 : index - 2'd1;
                    pos <= dir_q ? pos + 16'sd1 : pos - 16'sd1;
                    remaining <= remaining - 8'd1;
                    timer <= STEP_PERIOD - 16'd1;
                end
            end
        end
    end
endmodule
